// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap sequencer.
//   - `XLEN default data/PC width (shared with the rest of the core)
//   - FSM state encoding, exception code constants, mcause interrupt bit
`ifndef XLEN
`define XLEN 32
`endif

package trap_ctrl_pkg;

  // Sequencer states
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TRAP_WR = 2'd1;
  localparam logic [1:0] REDIR   = 2'd2;

  // Synchronous exception codes reported by WB
  localparam logic [3:0] ILLEGAL_INSTR = 4'd2;
  localparam logic [3:0] BREAKPOINT    = 4'd3;
  localparam logic [3:0] LOAD_MISALIGN = 4'd4;
  localparam logic [3:0] ECALL_M       = 4'd11;

  // Machine external interrupt code (used with the interrupt bit set)
  localparam logic [3:0] MEI_CODE = 4'd11;

  localparam int unsigned MCAUSE_IRQ_BIT = `XLEN - 1;

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer.
// Takes exception/mret reports from WB, writes mcause/mtval/mepc into the
// CSR file, then holds flush until fetch accepts a redirect to mtvec (trap)
// or mepc (mret).
// Optional build macro: TRAP_CTRL_IRQ_EN adds irq_i (level external
// interrupt) which takes an interrupt trap in IDLE.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_*_i                   retiring-instruction report from WB
//   mcause/mtval/mepc_*_o    CSR exception write port
//   mtvec_rdata_i/mepc_rdata_i  CSR read-back for redirect targets
//   flush_o                  kill younger in-flight instructions
//   redir_valid_o/redir_pc_o/redir_ready_i  redirect handshake with fetch
//   busy_o                   sequencer not idle, WB must not retire
`ifndef XLEN
`define XLEN 32
`endif

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned CAUSE_W = 4,
  parameter int unsigned XLEN    = `XLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_valid_i,
  input  logic [`XLEN-1:0]   wb_pc_i,
  input  logic               wb_excp_i,
  input  logic [CAUSE_W-1:0] wb_excp_code_i,
  input  logic [`XLEN-1:0]   wb_excp_tval_i,
  input  logic               wb_mret_i,
`ifdef TRAP_CTRL_IRQ_EN
  input  logic               irq_i,
`endif
  output logic               mcause_wen_o,
  output logic [`XLEN-1:0]   mcause_wdata_o,
  output logic               mtval_wen_o,
  output logic [`XLEN-1:0]   mtval_wdata_o,
  output logic               mepc_wen_o,
  output logic [`XLEN-1:0]   mepc_wdata_o,
  input  logic [`XLEN-1:0]   mtvec_rdata_i,
  input  logic [`XLEN-1:0]   mepc_rdata_i,
  output logic               flush_o,
  output logic               redir_valid_o,
  output logic [`XLEN-1:0]   redir_pc_o,
  input  logic               redir_ready_i,
  output logic               busy_o
);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            wen_q, wen_d;
  logic            redir_valid_q, redir_valid_d;
  logic            busy_q, busy_d;

  logic trap_trig, mret_trig;

  assign trap_trig = wb_valid_i & wb_excp_i;
  assign mret_trig = wb_valid_i & wb_mret_i & ~wb_excp_i;

  // Next-state and capture logic
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    epc_d    = epc_q;
    target_d = target_q;
    wen_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trap_trig) begin
          cause_d = XLEN'(wb_excp_code_i);
          tval_d  = wb_excp_tval_i;
          epc_d   = wb_pc_i & ~XLEN'(3);
          wen_d   = 1'b1;
          state_d = TRAP_WR;
        end
`ifdef TRAP_CTRL_IRQ_EN
        else if (irq_i & wb_valid_i) begin
          // Interrupted instruction retires, so return past it
          cause_d = (XLEN'(1) << MCAUSE_IRQ_BIT) | XLEN'(MEI_CODE);
          tval_d  = '0;
          epc_d   = wb_pc_i + XLEN'(4);
          wen_d   = 1'b1;
          state_d = TRAP_WR;
        end
`endif
        else if (mret_trig) begin
          target_d = mepc_rdata_i;
          state_d  = REDIR;
        end
      end
      TRAP_WR: begin
        target_d = mtvec_rdata_i;
        state_d  = REDIR;
      end
      REDIR: begin
        if (redir_valid_q & redir_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    redir_valid_d = (state_d == REDIR);
    busy_d        = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cause_q       <= '0;
      tval_q        <= '0;
      epc_q         <= '0;
      target_q      <= '0;
      wen_q         <= 1'b0;
      redir_valid_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      tval_q        <= tval_d;
      epc_q         <= epc_d;
      target_q      <= target_d;
      wen_q         <= wen_d;
      redir_valid_q <= redir_valid_d;
      busy_q        <= busy_d;
    end
  end

  // Reset during TRAP_WR must suppress the already-registered write strobe
  assign mcause_wen_o   = wen_q & ~rst;
  assign mtval_wen_o    = wen_q & ~rst;
  assign mepc_wen_o     = wen_q & ~rst;
  assign mcause_wdata_o = cause_q;
  assign mtval_wdata_o  = tval_q;
  assign mepc_wdata_o   = epc_q;
  assign redir_valid_o  = redir_valid_q;
  assign redir_pc_o     = target_q;
  assign flush_o        = busy_q;
  assign busy_o         = busy_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer. It is the initiator side of the CSR exception write port and the consumer of the mtvec/mepc read-back.
- Takes exception and mret reports from the WB stage and sequences the mcause/mtval/mepc writes into the CSR file.
- Holds the pipeline flush until fetch accepts a redirect to mtvec (trap) or mepc (mret).

Parameters:
- CAUSE_W, 4, width of the exception code reported by WB; zero-extended to XLEN in mcause.
- XLEN, 32, data/PC width. Matches the `XLEN define, which is used for all XLEN-wide ports.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wb_valid_i  in  1  WB holds a retiring instruction
- wb_pc_i  in  XLEN  PC of WB instruction
- wb_excp_i  in  1  WB instruction raised an exception
- wb_excp_code_i  in  CAUSE_W  exception code
- wb_excp_tval_i  in  XLEN  faulting address/instruction
- wb_mret_i  in  1  WB instruction is mret
- mcause_wen_o  out  1  CSR mcause write enable
- mcause_wdata_o  out  XLEN  mcause write data
- mtval_wen_o  out  1  CSR mtval write enable
- mtval_wdata_o  out  XLEN  mtval write data
- mepc_wen_o  out  1  CSR mepc write enable
- mepc_wdata_o  out  XLEN  mepc write data
- mtvec_rdata_i  in  XLEN  trap vector from CSR file
- mepc_rdata_i  in  XLEN  mepc from CSR file
- flush_o  out  1  kill all younger in-flight instructions
- redir_valid_o  out  1  PC redirect request to fetch
- redir_pc_o  out  XLEN  redirect target
- redir_ready_i  in  1  fetch accepts redirect
- busy_o  out  1  sequencer not IDLE; WB must not retire

Behaviour:
- Reset: state IDLE; all _o signals 0; capture registers 0.
- States: IDLE, TRAP_WR, REDIR.
- Trigger, in IDLE only:
  - Trap trigger = wb_valid_i & wb_excp_i.
  - mret trigger = wb_valid_i & wb_mret_i & ~wb_excp_i. Exception wins if both are set.
  - wb_* inputs are ignored outside IDLE.
- Trap, cycle T (IDLE, trigger seen):
  - Register cause = zero-extended code, tval, epc = {wb_pc_i[XLEN-1:2], 2'b00}.
  - Next state TRAP_WR.
- Trap, cycle T+1 (TRAP_WR):
  - mcause_wen_o, mtval_wen_o, mepc_wen_o = 1 for exactly one cycle, wdata = captured values.
  - Next state REDIR, target = mtvec_rdata_i.
- mret, cycle T: next state REDIR, target = mepc_rdata_i sampled at T. No CSR writes.
- REDIR:
  - redir_valid_o = 1; redir_pc_o = registered target, held stable.
  - Leave to IDLE on the cycle redir_valid_o & redir_ready_i.
  - Ready already high on entry gives a 1-cycle REDIR.
- flush_o and busy_o are registered. Both are 1 in every non-IDLE state and 0 in IDLE. flush_o drops the cycle after the handshake.
- Trap latency: trigger to redir_valid_o = 2 cycles. mret latency: 1 cycle.
- wdata outputs hold their last captured value when wen = 0.
- rst asserted mid-sequence: returns to IDLE next edge. Any pending CSR write is dropped; no partial wen is emitted.

Optional Feature:
- Macro: TRAP_CTRL_IRQ_EN.
- With macro:
  - Adds port irq_i (in, 1, level external interrupt).
  - In IDLE, irq_i & ~wb_excp_i & wb_valid_i takes an interrupt trap.
  - mcause = {1'b1, zeros, 4'd11}; mtval = 0; mepc = wb_pc_i + 4 (the instruction retires).
  - A synchronous exception in the same cycle has priority over irq_i.
- Without macro: no irq_i port; only synchronous exceptions and mret.

Decomposition:
- Shared package/define file holds:
  - State encoding: IDLE=2'd0, TRAP_WR=2'd1, REDIR=2'd2.
  - Exception code constants: ILLEGAL_INSTR=2, BREAKPOINT=3, LOAD_MISALIGN=4, ECALL_M=11.
  - MCAUSE_IRQ_BIT = XLEN-1.
- No sub-module; a single FSM plus capture registers.

Test Plan:
- Illegal instruction: wb_valid=1, excp=1, code=2, pc=0x100, tval=0x00000013, mtvec=40, redir_ready=1.
  - T+1: mcause_wen=1 with mcause_wdata=2, mtval_wdata=0x13, mepc_wdata=0x100.
  - T+2: redir_valid=1 with redir_pc=40; IDLE at T+3.
- mret with mepc_rdata=0x104 -> T+1 redir_pc=0x104; no wen asserted at any cycle.
- Backpressure: redir_ready=0 for 5 cycles, then 1 -> redir_pc stable and flush_o=1 for all 5 stall cycles; wb_excp pulses during the stall are ignored.
- excp=1 and mret=1 simultaneously, code=3 -> trap path taken; mcause_wdata=3.
- rst pulse in TRAP_WR -> no wen that cycle; next cycle all outputs 0, busy_o=0.
- (TRAP_CTRL_IRQ_EN) irq_i=1, pc=0x200, no excp -> mcause_wdata=0x8000000B, mepc_wdata=0x204, mtval_wdata=0.
